// File: rtl/core_control_exception_sched_pkg.sv
// Shared types for the exception entry scheduler: exception classes,
// entry steps, PSR modes, vector offsets and per-class entry attributes.
`timescale 1ns/1ps
package core_control_exception_sched_pkg;

    // Listed in architectural priority order, highest first.
    typedef enum logic [2:0] {
        EXC_DABT = 3'd0,
        EXC_FIQ  = 3'd1,
        EXC_IRQ  = 3'd2,
        EXC_PABT = 3'd3,
        EXC_UND  = 3'd4,
        EXC_SWI  = 3'd5
    } exc_class_t;

    typedef enum logic [1:0] {
        STEP_SAVE = 2'd0,
        STEP_LINK = 2'd1,
        STEP_JUMP = 2'd2
    } ctrl_exc_step_t;

    typedef enum logic [4:0] {
        MODE_USR = 5'h10,
        MODE_FIQ = 5'h11,
        MODE_IRQ = 5'h12,
        MODE_SVC = 5'h13,
        MODE_ABT = 5'h17,
        MODE_UND = 5'h1B
    } psr_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_LINK = 2'd2,
        ST_JUMP = 2'd3
    } fsm_state_t;

    localparam logic [15:0] VEC_UND  = 16'h0004;
    localparam logic [15:0] VEC_SWI  = 16'h0008;
    localparam logic [15:0] VEC_PABT = 16'h000C;
    localparam logic [15:0] VEC_DABT = 16'h0010;
    localparam logic [15:0] VEC_IRQ  = 16'h0018;
    localparam logic [15:0] VEC_FIQ  = 16'h001C;

    // Bit positions of the sticky (pulse-latched) sources.
    localparam int PEND_W    = 4;
    localparam int PEND_DABT = 0;
    localparam int PEND_PABT = 1;
    localparam int PEND_UND  = 2;
    localparam int PEND_SWI  = 3;

    typedef struct packed {
        psr_mode_t          mode;
        logic [15:0]        vec;
        logic [3:0]         lr_offset;
        logic               set_f;
        logic [PEND_W-1:0]  pend_mask;
    } exc_attr_t;

    function automatic exc_attr_t exc_attr(exc_class_t cls);
        exc_attr_t a;
        a = '{MODE_ABT, VEC_DABT, 4'd8, 1'b0, PEND_W'(1) << PEND_DABT};
        unique case (cls)
            EXC_DABT: a = '{MODE_ABT, VEC_DABT, 4'd8, 1'b0,
                            PEND_W'(1) << PEND_DABT};
            EXC_FIQ:  a = '{MODE_FIQ, VEC_FIQ, 4'd4, 1'b1, '0};
            EXC_IRQ:  a = '{MODE_IRQ, VEC_IRQ, 4'd4, 1'b0, '0};
            EXC_PABT: a = '{MODE_ABT, VEC_PABT, 4'd4, 1'b0,
                            PEND_W'(1) << PEND_PABT};
            EXC_UND:  a = '{MODE_UND, VEC_UND, 4'd4, 1'b0,
                            PEND_W'(1) << PEND_UND};
            EXC_SWI:  a = '{MODE_SVC, VEC_SWI, 4'd4, 1'b0,
                            PEND_W'(1) << PEND_SWI};
            default:  a = '{MODE_ABT, VEC_DABT, 4'd8, 1'b0,
                            PEND_W'(1) << PEND_DABT};
        endcase
        return a;
    endfunction

endpackage

// File: rtl/core_control_exception_sched_prio.sv
// Combinational exception priority encoder.
// Ports: pend (sticky sources), irq_s/fiq_s + masks in; winning class + any out.
`timescale 1ns/1ps
module core_control_exception_sched_prio
    import core_control_exception_sched_pkg::*;
(
    input  logic [PEND_W-1:0] pend,
    input  logic              irq_s,
    input  logic              fiq_s,
    input  logic              cpsr_i,
    input  logic              cpsr_f,
    output exc_class_t        cls,
    output logic              any
);

    always_comb begin
        any = 1'b1;
        cls = EXC_DABT;
        if (pend[PEND_DABT])
            cls = EXC_DABT;
        else if (fiq_s && !cpsr_f)
            cls = EXC_FIQ;
        else if (irq_s && !cpsr_i)
            cls = EXC_IRQ;
        else if (pend[PEND_PABT])
            cls = EXC_PABT;
        else if (pend[PEND_UND])
            cls = EXC_UND;
        else if (pend[PEND_SWI])
            cls = EXC_SWI;
        else
            any = 1'b0;
    end

endmodule

// File: rtl/core_control_exception_sched.sv
// Exception entry scheduler: latches sources, arbitrates at insn boundaries,
// sequences SAVE/LINK/JUMP steps to core control over a valid/ready handshake.
// Ports: clk, rst_n (sync, active low); insn_boundary, high_vectors,
//   cpsr_i/f, irq/fiq pins, fault pulses, entry_ready in;
//   entry_valid/step/mode/vector/lr_offset/set_f and busy out.
`timescale 1ns/1ps
module core_control_exception_sched
    import core_control_exception_sched_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        insn_boundary,
    input  logic        high_vectors,
    input  logic        cpsr_i,
    input  logic        cpsr_f,
    input  logic        irq,
    input  logic        fiq,
    input  logic        undefined,
    input  logic        swi,
    input  logic        prefetch_abort,
    input  logic        data_abort,
    input  logic        entry_ready,
    output logic        entry_valid,
    output logic [1:0]  entry_step,
    output logic [4:0]  entry_mode,
    output logic [31:0] entry_vector,
    output logic [3:0]  entry_lr_offset,
    output logic        entry_set_f,
    output logic        busy
);

    logic [IRQ_SYNC_STAGES-1:0] irq_sync;
    logic [IRQ_SYNC_STAGES-1:0] fiq_sync;
    logic                       irq_s;
    logic                       fiq_s;
    logic [PEND_W-1:0]          pend_q;
    logic [PEND_W-1:0]          pulse;
    logic [PEND_W-1:0]          pend_cur;
    logic [PEND_W-1:0]          cls_mask;
    logic                       again_q;
    fsm_state_t                 state_q;
    fsm_state_t                 state_d;
    exc_class_t                 cls_q;
    exc_class_t                 arb_cls;
    logic                       arb_any;
    logic                       take;
    logic                       jump_acc;
    exc_attr_t                  attr;

    assign irq_s    = irq_sync[IRQ_SYNC_STAGES-1];
    assign fiq_s    = fiq_sync[IRQ_SYNC_STAGES-1];
    assign pulse    = {swi, undefined, prefetch_abort, data_abort};
    // Same-cycle pulses take part in arbitration.
    assign pend_cur = pend_q | pulse;
    assign take     = (state_q == ST_IDLE) && insn_boundary && arb_any;
    assign jump_acc = (state_q == ST_JUMP) && entry_ready;
    assign attr     = exc_attr(cls_q);
    assign cls_mask = attr.pend_mask;

    core_control_exception_sched_prio u_prio (
        .pend   (pend_cur),
        .irq_s  (irq_s),
        .fiq_s  (fiq_s),
        .cpsr_i (cpsr_i),
        .cpsr_f (cpsr_f),
        .cls    (arb_cls),
        .any    (arb_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (take) state_d = ST_SAVE;
            ST_SAVE: if (entry_ready) state_d = ST_LINK;
            ST_LINK: if (entry_ready) state_d = ST_JUMP;
            ST_JUMP: if (entry_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        entry_valid     = 1'b0;
        entry_step      = 2'd0;
        entry_mode      = 5'd0;
        entry_vector    = 32'd0;
        entry_lr_offset = 4'd0;
        entry_set_f     = 1'b0;
        busy            = 1'b0;
        if (state_q != ST_IDLE) begin
            entry_valid     = 1'b1;
            busy            = 1'b1;
            entry_mode      = attr.mode;
            entry_vector    = {{16{high_vectors}}, attr.vec};
            entry_lr_offset = attr.lr_offset;
            entry_set_f     = attr.set_f;
            unique case (state_q)
                ST_SAVE: entry_step = STEP_SAVE;
                ST_LINK: entry_step = STEP_LINK;
                ST_JUMP: entry_step = STEP_JUMP;
                default: entry_step = STEP_SAVE;
            endcase
        end
    end

    // again_q records a fresh fault of the class being entered, so the
    // clear at JUMP does not swallow it; repeats collapse to one entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_sync <= '0;
            fiq_sync <= '0;
            pend_q   <= '0;
            again_q  <= 1'b0;
            cls_q    <= EXC_DABT;
        end else begin
            irq_sync[0] <= irq;
            fiq_sync[0] <= fiq;
            for (int i = 1; i < IRQ_SYNC_STAGES; i++) begin
                irq_sync[i] <= irq_sync[i-1];
                fiq_sync[i] <= fiq_sync[i-1];
            end
            if (take)
                cls_q <= arb_cls;
            if (jump_acc) begin
                again_q <= 1'b0;
                pend_q  <= (pend_cur & ~cls_mask)
                         | (again_q ? cls_mask : '0)
                         | (pulse & cls_mask);
            end else begin
                if (busy && |(pulse & cls_mask))
                    again_q <= 1'b1;
                pend_q <= pend_cur;
            end
        end
    end

endmodule
